// File: rtl/rtl_logic_pkg.sv
// Shared definitions for the rtl_logic block and its response checker:
// checker state encoding and the reference equations of the two-stage pipeline.
package rtl_logic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } chk_state_t;

    function automatic logic ref_f(input logic x1, input logic x2);
        return x1 & x2;
    endfunction

    function automatic logic ref_g(input logic f, input logic x3);
        return f | x3;
    endfunction

endpackage

// File: rtl/rtl_logic_ref.sv
// Cycle-accurate reference copy of rtl_logic; unlike the real block it is
// cleared by reset so the checker starts from a known model state.
module rtl_logic_ref
    import rtl_logic_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    output logic exp_f,
    output logic exp_g
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            exp_f <= 1'b0;
            exp_g <= 1'b0;
        end else begin
            exp_f <= ref_f(x1, x2);
            exp_g <= ref_g(exp_f, x3);
        end
    end

endmodule

// File: rtl/rtl_logic_checker.sv
// Response checker for rtl_logic: runs the reference model alongside the DUT,
// compares f/g every CHECK cycle and keeps sticky error, counters and first-fail index.
module rtl_logic_checker
    import rtl_logic_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x1,
    input  logic             x2,
    input  logic             x3,
    input  logic             f,
    input  logic             g,
    output logic             checking,
    output logic             halted,
    output logic             error,
    output logic             fail_f,
    output logic             fail_g,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             exp_f;
    logic             exp_g;
    logic [1:0]       dut_out;
    logic [1:0]       ref_out;
    logic [1:0]       mis;
    logic             mismatch;

    chk_state_t       state_reg;
    logic             error_reg;
    logic             fail_f_reg;
    logic             fail_g_reg;
    logic [CNT_W-1:0] chk_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [CNT_W-1:0] first_fail_reg;
    logic [CNT_W-1:0] chk_cnt_next;
    logic [CNT_W-1:0] err_cnt_next;

    rtl_logic_ref u_ref (
        .clock   (clock),
        .reset_n (reset_n),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .exp_f   (exp_f),
        .exp_g   (exp_g)
    );

    assign dut_out = {g, f};
    assign ref_out = {exp_g, exp_f};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
            assign mis[gi] = dut_out[gi] ^ ref_out[gi];
        end
    endgenerate

    // A double mismatch is still a single failed compare.
    assign mismatch = |mis;

    assign chk_cnt_next = (chk_cnt_reg == CNT_MAX) ? chk_cnt_reg : chk_cnt_reg + CNT_ONE;
    assign err_cnt_next = (err_cnt_reg == CNT_MAX) ? err_cnt_reg : err_cnt_reg + CNT_ONE;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            error_reg      <= 1'b0;
            fail_f_reg     <= 1'b0;
            fail_g_reg     <= 1'b0;
            chk_cnt_reg    <= '0;
            err_cnt_reg    <= '0;
            first_fail_reg <= '1;
        end else if (state_reg != IDLE && !en) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_reg      <= PRIME;
                        error_reg      <= 1'b0;
                        fail_f_reg     <= 1'b0;
                        fail_g_reg     <= 1'b0;
                        chk_cnt_reg    <= '0;
                        err_cnt_reg    <= '0;
                        first_fail_reg <= '1;
                    end
                end
                PRIME: state_reg <= CHECK;
                CHECK: begin
                    fail_f_reg  <= mis[0];
                    fail_g_reg  <= mis[1];
                    chk_cnt_reg <= chk_cnt_next;
                    if (mismatch) begin
                        err_cnt_reg <= err_cnt_next;
                        error_reg   <= 1'b1;
                        // error_reg, not err_cnt, marks the first failure so saturation cannot confuse it
                        if (!error_reg) begin
                            first_fail_reg <= chk_cnt_reg;
                        end
                        if (STOP_ON_FAIL) begin
                            state_reg <= HALT;
                        end
                    end
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    assign checking   = (state_reg == CHECK);
    assign halted     = (state_reg == HALT);
    assign error      = error_reg;
    assign fail_f     = fail_f_reg;
    assign fail_g     = fail_g_reg;
    assign chk_cnt    = chk_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign first_fail = first_fail_reg;

endmodule

// File: tb/tb_rtl_logic_checker.sv
// Scoreboard bench for rtl_logic_checker: three checker instances watch one
// behavioural rtl_logic whose g output can be forced low while x3=1.
module tb_rtl_logic_checker;
    import rtl_logic_pkg::*;

    localparam int S_CHECKING = 0, S_HALTED = 1, S_ERROR = 2, S_FAIL_F = 3,
                   S_FAIL_G = 4, S_CHK = 5, S_ERR = 6, S_FIRST = 7;
    localparam int I_A = 0, I_B = 1, I_C = 2;

    typedef struct {
        int          cyc;
        int          inst;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic reset_n, en, x1, x2, x3, fault;
    logic f_m = 1'b0, g_m = 1'b0;
    logic g_dut;

    // Behavioural stand-in for the unreset rtl_logic block.
    always @(posedge clk) begin
        f_m <= x1 & x2;
        g_m <= f_m | x3;
    end
    assign g_dut = (fault && x3) ? 1'b0 : g_m;

    logic        a_checking, a_halted, a_error, a_fail_f, a_fail_g;
    logic [15:0] a_chk, a_err, a_first;
    logic        b_checking, b_halted, b_error, b_fail_f, b_fail_g;
    logic [15:0] b_chk, b_err, b_first;
    logic        c_checking, c_halted, c_error, c_fail_f, c_fail_g;
    logic [2:0]  c_chk, c_err, c_first;

    rtl_logic_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) u_a (
        .clock(clk), .reset_n(reset_n), .en(en), .x1(x1), .x2(x2), .x3(x3),
        .f(f_m), .g(g_dut), .checking(a_checking), .halted(a_halted), .error(a_error),
        .fail_f(a_fail_f), .fail_g(a_fail_g), .chk_cnt(a_chk), .err_cnt(a_err),
        .first_fail(a_first)
    );
    rtl_logic_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) u_b (
        .clock(clk), .reset_n(reset_n), .en(en), .x1(x1), .x2(x2), .x3(x3),
        .f(f_m), .g(g_dut), .checking(b_checking), .halted(b_halted), .error(b_error),
        .fail_f(b_fail_f), .fail_g(b_fail_g), .chk_cnt(b_chk), .err_cnt(b_err),
        .first_fail(b_first)
    );
    rtl_logic_checker #(.CNT_W(3), .STOP_ON_FAIL(1'b1)) u_c (
        .clock(clk), .reset_n(reset_n), .en(en), .x1(x1), .x2(x2), .x3(x3),
        .f(f_m), .g(g_dut), .checking(c_checking), .halted(c_halted), .error(c_error),
        .fail_f(c_fail_f), .fail_g(c_fail_g), .chk_cnt(c_chk), .err_cnt(c_err),
        .first_fail(c_first)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [15:0] get_val(int inst, int sig);
        logic [15:0] v;
        v = '0;
        case (inst)
            I_A: case (sig)
                S_CHECKING: v = {15'd0, a_checking};
                S_HALTED:   v = {15'd0, a_halted};
                S_ERROR:    v = {15'd0, a_error};
                S_FAIL_F:   v = {15'd0, a_fail_f};
                S_FAIL_G:   v = {15'd0, a_fail_g};
                S_CHK:      v = a_chk;
                S_ERR:      v = a_err;
                default:    v = a_first;
            endcase
            I_B: case (sig)
                S_CHECKING: v = {15'd0, b_checking};
                S_HALTED:   v = {15'd0, b_halted};
                S_ERROR:    v = {15'd0, b_error};
                S_FAIL_F:   v = {15'd0, b_fail_f};
                S_FAIL_G:   v = {15'd0, b_fail_g};
                S_CHK:      v = b_chk;
                S_ERR:      v = b_err;
                default:    v = b_first;
            endcase
            default: case (sig)
                S_CHECKING: v = {15'd0, c_checking};
                S_HALTED:   v = {15'd0, c_halted};
                S_ERROR:    v = {15'd0, c_error};
                S_FAIL_F:   v = {15'd0, c_fail_f};
                S_FAIL_G:   v = {15'd0, c_fail_g};
                S_CHK:      v = {13'd0, c_chk};
                S_ERR:      v = {13'd0, c_err};
                default:    v = {13'd0, c_first};
            endcase
        endcase
        return v;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            logic [15:0] act;
            mon_e = sb_q.pop_front();
            act = get_val(mon_e.inst, mon_e.sig);
            vectors++;
            if (act !== mon_e.exp) begin
                miscompares++;
                $display("FAIL %s: inst %0d cycle %0d got %0h expected %0h",
                         mon_e.name, mon_e.inst, cyc, act, mon_e.exp);
            end
        end
    end

    task automatic expect_v(int inst, int sig, logic [15:0] v, string nm);
        exp_t e;
        e.cyc = cyc; e.inst = inst; e.sig = sig; e.exp = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic expect_reset(int inst, string tag);
        expect_v(inst, S_CHECKING, 16'd0, {tag, "_checking"});
        expect_v(inst, S_HALTED,   16'd0, {tag, "_halted"});
        expect_v(inst, S_ERROR,    16'd0, {tag, "_error"});
        expect_v(inst, S_FAIL_F,   16'd0, {tag, "_fail_f"});
        expect_v(inst, S_FAIL_G,   16'd0, {tag, "_fail_g"});
        expect_v(inst, S_CHK,      16'd0, {tag, "_chk_cnt"});
        expect_v(inst, S_ERR,      16'd0, {tag, "_err_cnt"});
        expect_v(inst, S_FIRST, (inst == I_C) ? 16'h0007 : 16'hFFFF, {tag, "_first_fail"});
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(logic [2:0] v);
        {x1, x2, x3} = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pat [5];
        logic [2:0] vec [11];
        pat = '{3'b001, 3'b110, 3'b011, 3'b110, 3'b001};
        vec = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                3'b000, 3'b001, 3'b110, 3'b111, 3'b001};

        reset_n = 1'b0; en = 1'b0; fault = 1'b0; drive(3'b000);
        tick(2);
        expect_reset(I_A, "rst_a");
        expect_reset(I_B, "rst_b");
        expect_reset(I_C, "rst_c");

        // Clean run, stimulus on a 15 ns grid unrelated to the clock.
        reset_n = 1'b1; en = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    drive(pat[k % 5]);
                    #15;
                end
            end
            begin
                tick(1);
                expect_v(I_A, S_CHECKING, 16'd0, "prime_checking");
                tick(1);
                expect_v(I_A, S_CHECKING, 16'd1, "check_entry");
                expect_v(I_A, S_CHK, 16'd0, "check_entry_cnt");
                tick(1);
                expect_v(I_A, S_CHK, 16'd1, "first_compare");
                tick(6);
                expect_v(I_A, S_CHK, 16'd7, "clean_cnt7");
                expect_v(I_C, S_CHK, 16'd7, "sat_reach");
                tick(3);
                expect_v(I_C, S_CHK, 16'd7, "sat_nowrap");
                expect_v(I_A, S_CHK, 16'd10, "clean_cnt10");
                en = 1'b0;
                tick(1);
                expect_v(I_A, S_CHECKING, 16'd0, "clean_idle");
                expect_v(I_A, S_CHK, 16'd10, "clean_chk");
                expect_v(I_A, S_ERR, 16'd0, "clean_err");
                expect_v(I_A, S_ERROR, 16'd0, "clean_error");
                expect_v(I_A, S_FIRST, 16'hFFFF, "clean_first");
                expect_v(I_C, S_ERR, 16'd0, "clean_c_err");
            end
        join

        // g stuck-at-0 whenever x3=1; mismatches land on compares E4, E5 and E10.
        fault = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vec[i]);
            if (i == 0) en = 1'b1;
            tick(1);
            if (i == 4) begin
                expect_v(I_A, S_FAIL_G, 16'd1, "a_fail_g");
                expect_v(I_A, S_FAIL_F, 16'd0, "a_fail_f");
                expect_v(I_A, S_ERROR, 16'd1, "a_error");
                expect_v(I_A, S_HALTED, 16'd1, "a_halted");
                expect_v(I_A, S_CHECKING, 16'd0, "a_not_checking");
                expect_v(I_A, S_ERR, 16'd1, "a_err1");
                expect_v(I_A, S_CHK, 16'd3, "a_chk3");
                expect_v(I_A, S_FIRST, 16'd2, "a_first");
                expect_v(I_B, S_FAIL_G, 16'd1, "b_fail_g");
                expect_v(I_B, S_CHECKING, 16'd1, "b_checking");
                expect_v(I_B, S_CHK, 16'd3, "b_chk3");
            end
            if (i == 5) begin
                expect_v(I_B, S_ERR, 16'd2, "b_err2");
                expect_v(I_B, S_CHK, 16'd4, "b_chk4");
                expect_v(I_A, S_CHK, 16'd3, "a_halt_hold");
            end
            if (i == 6) begin
                expect_v(I_B, S_FAIL_G, 16'd0, "b_fail_g_clear");
                expect_v(I_B, S_ERROR, 16'd1, "b_error_sticky");
            end
            if (i == 10) begin
                expect_v(I_B, S_ERR, 16'd3, "b_err3");
                expect_v(I_B, S_CHK, 16'd9, "b_chk9");
                expect_v(I_B, S_FIRST, 16'd2, "b_first_kept");
                expect_v(I_A, S_HALTED, 16'd1, "a_still_halted");
                expect_v(I_A, S_ERR, 16'd1, "a_err_hold");
            end
        end
        en = 1'b0;
        tick(1);
        expect_v(I_A, S_HALTED, 16'd0, "a_halt_exit");
        expect_v(I_A, S_ERR, 16'd1, "a_idle_err");
        expect_v(I_A, S_FIRST, 16'd2, "a_idle_first");
        expect_v(I_B, S_CHECKING, 16'd0, "b_idle");
        expect_v(I_B, S_CHK, 16'd9, "b_idle_chk");

        // Status held in IDLE, then a fresh run clears it.
        tick(2);
        expect_v(I_B, S_ERR, 16'd3, "b_hold_err");
        expect_v(I_B, S_ERROR, 16'd1, "b_hold_error");
        fault = 1'b0; drive(3'b000); en = 1'b1;
        tick(1);
        expect_v(I_B, S_CHK, 16'd0, "rerun_chk");
        expect_v(I_B, S_ERR, 16'd0, "rerun_err");
        expect_v(I_B, S_ERROR, 16'd0, "rerun_error");
        expect_v(I_B, S_FIRST, 16'hFFFF, "rerun_first");
        expect_v(I_B, S_CHECKING, 16'd0, "rerun_prime");
        expect_v(I_A, S_ERROR, 16'd0, "rerun_a_error");
        tick(1);
        expect_v(I_B, S_CHECKING, 16'd1, "rerun_check");
        expect_v(I_B, S_CHK, 16'd0, "rerun_no_cmp");
        tick(1);
        expect_v(I_B, S_CHK, 16'd1, "rerun_first_cmp");
        expect_v(I_A, S_CHK, 16'd1, "rerun_a_cmp");

        // Build an error, then reset mid-run with en still high.
        drive(3'b001); fault = 1'b1;
        tick(1);
        expect_v(I_B, S_ERROR, 16'd0, "pre_err_clean");
        tick(1);
        expect_v(I_B, S_ERROR, 16'd1, "pre_rst_error");
        expect_v(I_B, S_FIRST, 16'd2, "pre_rst_first");
        expect_v(I_A, S_HALTED, 16'd1, "pre_rst_halt");
        reset_n = 1'b0;
        tick(1);
        expect_reset(I_A, "midrst_a");
        expect_reset(I_B, "midrst_b");
        reset_n = 1'b1; fault = 1'b0;
        tick(1);
        expect_v(I_B, S_CHECKING, 16'd0, "post_rst_prime");
        tick(1);
        expect_v(I_B, S_CHECKING, 16'd1, "post_rst_check");
        en = 1'b0;
        tick(1);

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
